// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared frame buffer geometry constants and writer FSM state type
//
// Purpose: one place for the banked 320x240 frame buffer layout, used by the
// write controller and by the VGA read-address logic.
package fb_pkg;

  localparam int H_RES      = 320;
  localparam int V_RES      = 240;
  localparam int BANKS      = 16;
  localparam int BANK_BITS  = 4;
  localparam int ADDR_WIDTH = 13;
  localparam int DATA_WIDTH = 12;
  localparam int DEPTH      = 4800;
  localparam int X_WIDTH    = 9;
  localparam int Y_WIDTH    = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

endpackage

// File: rtl/fb_addr_map.sv
// rtl/fb_addr_map.sv - combinational pixel (x, y) to bank/word address mapping
//
// Purpose: bank = y mod BANKS, addr = (y div BANKS) * H_RES + x.
// Ports:
//   i_x, i_y     pixel coordinate
//   o_in_range   coordinate lies inside the visible frame
//   o_bank       bank index (low y bits)
//   o_addr       word address inside the bank
module fb_addr_map
  import fb_pkg::*;
(
  input  logic [X_WIDTH-1:0]    i_x,
  input  logic [Y_WIDTH-1:0]    i_y,
  output logic                  o_in_range,
  output logic [BANK_BITS-1:0]  o_bank,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  logic [ADDR_WIDTH:0] w_row;
  logic [ADDR_WIDTH:0] w_sum;

  assign w_row = {{(ADDR_WIDTH+1-(Y_WIDTH-BANK_BITS)){1'b0}}, i_y[Y_WIDTH-1:BANK_BITS]};

  // Row times 320 as (row << 8) + (row << 6); one spare bit catches overflow.
  assign w_sum = (w_row << 8) + (w_row << 6) + {{(ADDR_WIDTH+1-X_WIDTH){1'b0}}, i_x};

  assign o_in_range = (i_x < X_WIDTH'(H_RES)) && (i_y < Y_WIDTH'(V_RES)) && !w_sum[ADDR_WIDTH];
  assign o_bank     = i_y[BANK_BITS-1:0];
  assign o_addr     = w_sum[ADDR_WIDTH-1:0];

endmodule

// File: rtl/fb_writer.sv
// rtl/fb_writer.sv - write-side controller for the banked frame buffer
//
// Purpose: registers pixel writes onto one-hot per-bank write enables and
// runs a full-frame fill engine.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   i_valid/o_ready          pixel request handshake; i_x, i_y, i_color payload
//   i_clear, i_fill_color    fill request and its colour
//   o_we, o_addr, o_data     bank write port (one-hot/all-ones enable, shared addr/data)
//   o_busy                   fill in progress
//   o_clear_done             pulse after the last fill write
//   o_frame_done             pulse with the write of the bottom-right pixel
//   o_drop_cnt               saturating count of out-of-range requests
module fb_writer
  import fb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [X_WIDTH-1:0]    i_x,
  input  logic [Y_WIDTH-1:0]    i_y,
  input  logic [DATA_WIDTH-1:0] i_color,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_fill_color,
  output logic [BANKS-1:0]      o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_clear_done,
  output logic                  o_frame_done,
  output logic [15:0]           o_drop_cnt
);

  fb_state_t             r_state, w_state_nx;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nx;
  logic [DATA_WIDTH-1:0] r_fill, w_fill_nx;
  logic [BANKS-1:0]      r_we, w_we_nx;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nx;
  logic [DATA_WIDTH-1:0] r_data, w_data_nx;
  logic                  r_clear_done, w_clear_done_nx;
  logic                  r_frame_done, w_frame_done_nx;
  logic [15:0]           r_drop_cnt, w_drop_cnt_nx;

  logic                  w_accept;
  logic                  w_in_range;
  logic [BANK_BITS-1:0]  w_bank;
  logic [ADDR_WIDTH-1:0] w_map_addr;

  fb_addr_map u_addr_map (
    .i_x        (i_x),
    .i_y        (i_y),
    .o_in_range (w_in_range),
    .o_bank     (w_bank),
    .o_addr     (w_map_addr)
  );

  assign o_ready  = rst_n && (r_state == IDLE);
  assign w_accept = i_valid && o_ready;

  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_fill_nx       = r_fill;
    w_we_nx         = '0;
    w_addr_nx       = r_addr;
    w_data_nx       = r_data;
    w_clear_done_nx = 1'b0;
    w_frame_done_nx = 1'b0;
    w_drop_cnt_nx   = r_drop_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_nx = '0;
        if (w_accept) begin
          if (w_in_range) begin
            w_we_nx         = BANKS'(1) << w_bank;
            w_addr_nx       = w_map_addr;
            w_data_nx       = i_color;
            w_frame_done_nx = (i_x == X_WIDTH'(H_RES-1)) && (i_y == Y_WIDTH'(V_RES-1));
          end else if (r_drop_cnt != 16'hFFFF) begin
            w_drop_cnt_nx = r_drop_cnt + 16'd1;
          end
        end
        // A pixel accepted alongside the clear still issues; the fill follows it.
        if (i_clear) begin
          w_fill_nx  = i_fill_color;
          w_state_nx = CLEAR;
        end
      end
      CLEAR: begin
        // r_cnt reaching DEPTH means the last fill word went out last cycle.
        if (r_cnt == ADDR_WIDTH'(DEPTH)) begin
          w_clear_done_nx = 1'b1;
          w_cnt_nx        = '0;
          w_state_nx      = IDLE;
        end else begin
          w_we_nx   = '1;
          w_addr_nx = r_cnt;
          w_data_nx = r_fill;
          w_cnt_nx  = r_cnt + ADDR_WIDTH'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_fill       <= '0;
      r_we         <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_clear_done <= 1'b0;
      r_frame_done <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_fill       <= w_fill_nx;
      r_we         <= w_we_nx;
      r_addr       <= w_addr_nx;
      r_data       <= w_data_nx;
      r_clear_done <= w_clear_done_nx;
      r_frame_done <= w_frame_done_nx;
      r_drop_cnt   <= w_drop_cnt_nx;
    end
  end

  assign o_we         = r_we;
  assign o_addr       = r_addr;
  assign o_data       = r_data;
  assign o_busy       = (r_state == CLEAR);
  assign o_clear_done = r_clear_done;
  assign o_frame_done = r_frame_done;
  assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_fb_writer.sv
// tb/tb_fb_writer.sv - self-checking bench for fb_writer
module tb_fb_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_valid = 1'b0;
  logic [8:0]  i_x = '0;
  logic [7:0]  i_y = '0;
  logic [11:0] i_color = '0;
  logic        i_clear = 1'b0;
  logic [11:0] i_fill_color = '0;
  logic        o_ready;
  logic [15:0] o_we;
  logic [12:0] o_addr;
  logic [11:0] o_data;
  logic        o_busy;
  logic        o_clear_done;
  logic        o_frame_done;
  logic [15:0] o_drop_cnt;

  int n_checks = 0;
  int n_fail = 0;

  fb_writer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_x          (i_x),
    .i_y          (i_y),
    .i_color      (i_color),
    .i_clear      (i_clear),
    .i_fill_color (i_fill_color),
    .o_we         (o_we),
    .o_addr       (o_addr),
    .o_data       (o_data),
    .o_busy       (o_busy),
    .o_clear_done (o_clear_done),
    .o_frame_done (o_frame_done),
    .o_drop_cnt   (o_drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference mapping straight from the frame layout: row band times width plus column.
  function automatic logic [12:0] ref_addr(input int x, input int y);
    return 13'((y / 16) * 320 + x);
  endfunction

  function automatic logic [15:0] ref_we(input int y);
    return 16'(1 << (y % 16));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    i_valid = 1'b1; i_x = 9'd5; i_y = 8'd0; i_color = 12'hF00;
    repeat (3) tick();
    n_checks++;
    if ({o_we, o_addr, o_data, o_busy, o_clear_done, o_frame_done, o_drop_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs we=%h addr=%0d data=%h busy=%b cd=%b fd=%b drop=%0d required all 0",
               o_we, o_addr, o_data, o_busy, o_clear_done, o_frame_done, o_drop_cnt);
    end
    n_checks++;
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b required 0", o_ready); end
    rst_n = 1'b1; i_valid = 1'b0;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b required 1", o_ready); end
    tick();
    n_checks++;
    if (o_we !== 16'h0) begin n_fail++; $display("FAIL release_no_we got %h required 0", o_we); end
  endtask

  task automatic test_basic_write();
    i_valid = 1'b1; i_x = 9'd5; i_y = 8'd0; i_color = 12'hF00;
    tick();
    i_valid = 1'b0;
    n_checks++;
    if (o_we !== 16'h0001 || o_addr !== 13'd5 || o_data !== 12'hF00) begin
      n_fail++;
      $display("FAIL basic_write we=%h addr=%0d data=%h required 0001/5/f00", o_we, o_addr, o_data);
    end
    tick();
    n_checks++;
    if (o_we !== 16'h0 || o_addr !== 13'd5 || o_data !== 12'hF00) begin
      n_fail++;
      $display("FAIL basic_idle_hold we=%h addr=%0d data=%h required 0000/5/f00", o_we, o_addr, o_data);
    end
  endtask

  task automatic test_last_pixel();
    i_valid = 1'b1; i_x = 9'd319; i_y = 8'd239; i_color = 12'h5A5;
    tick();
    i_valid = 1'b0;
    n_checks++;
    if (o_we !== 16'h8000 || o_addr !== 13'd4799 || o_data !== 12'h5A5 || o_frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL last_pixel we=%h addr=%0d data=%h fd=%b required 8000/4799/5a5/1",
               o_we, o_addr, o_data, o_frame_done);
    end
    tick();
    n_checks++;
    if (o_frame_done !== 1'b0 || o_we !== 16'h0) begin
      n_fail++;
      $display("FAIL frame_done_pulse fd=%b we=%h required 0/0000", o_frame_done, o_we);
    end
  endtask

  task automatic test_range();
    i_valid = 1'b1; i_x = 9'd320; i_y = 8'd10; i_color = 12'h111;
    tick();
    i_x = 9'd0; i_y = 8'd240;
    n_checks++;
    if (o_we !== 16'h0 || o_drop_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL range_x we=%h drop=%0d required 0000/1", o_we, o_drop_cnt);
    end
    tick();
    i_valid = 1'b0;
    n_checks++;
    if (o_we !== 16'h0 || o_drop_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL range_y we=%h drop=%0d required 0000/2", o_we, o_drop_cnt);
    end
  endtask

  task automatic test_random();
    int m_drop = 2;
    logic [12:0] m_addr = '0;
    logic [11:0] m_data = '0;
    for (int i = 0; i < 300; i++) begin
      int x, y;
      logic v;
      logic [11:0] c;
      logic [15:0] e_we;
      logic e_fd;
      v = (i == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      x = (i == 0) ? 10 : int'($urandom_range(0, 335));
      y = (i == 0) ? 20 : int'($urandom_range(0, 250));
      c = 12'($urandom);
      i_valid = v; i_x = 9'(x); i_y = 8'(y); i_color = c;
      e_we = '0; e_fd = 1'b0;
      if (v) begin
        if (x < 320 && y < 240) begin
          e_we = ref_we(y); m_addr = ref_addr(x, y); m_data = c;
          e_fd = (x == 319 && y == 239);
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
      n_checks++;
      if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rand_ready i=%0d got %b required 1", i, o_ready); end
      tick();
      n_checks++;
      if (o_we !== e_we || o_addr !== m_addr || o_data !== m_data) begin
        n_fail++;
        $display("FAIL rand_write i=%0d x=%0d y=%0d we=%h addr=%0d data=%h required %h/%0d/%h",
                 i, x, y, o_we, o_addr, o_data, e_we, m_addr, m_data);
      end
      n_checks++;
      if (o_frame_done !== e_fd || o_drop_cnt !== 16'(m_drop)) begin
        n_fail++;
        $display("FAIL rand_status i=%0d fd=%b drop=%0d required %b/%0d", i, o_frame_done, o_drop_cnt, e_fd, m_drop);
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic test_clear_pending();
    int bad = 0;
    i_valid = 1'b1; i_x = 9'd1; i_y = 8'd1; i_color = 12'h777;
    i_clear = 1'b1; i_fill_color = 12'h00F;
    tick();
    i_clear = 1'b0; i_fill_color = 12'h000;
    i_x = 9'd7; i_y = 8'd3; i_color = 12'hABC;
    n_checks++;
    if (o_we !== 16'h0002 || o_addr !== 13'd1 || o_data !== 12'h777 || o_busy !== 1'b1 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_pending_pixel we=%h addr=%0d data=%h busy=%b rdy=%b required 0002/1/777/1/0",
               o_we, o_addr, o_data, o_busy, o_ready);
    end
    for (int k = 0; k < 4800; k++) begin
      tick();
      i_clear = (k == 100);
      if (o_we !== 16'hFFFF || o_addr !== 13'(k) || o_data !== 12'h00F || o_busy !== 1'b1 ||
          o_ready !== 1'b0 || o_clear_done !== 1'b0) begin
        if (bad == 0)
          $display("first bad fill cycle k=%0d we=%h addr=%0d data=%h busy=%b", k, o_we, o_addr, o_data, o_busy);
        bad++;
      end
    end
    i_clear = 1'b0;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL clear_sweep bad_cycles=%0d required 0", bad); end
    tick();
    n_checks++;
    if (o_clear_done !== 1'b1 || o_we !== 16'h0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_done cd=%b we=%h busy=%b rdy=%b required 1/0000/0/1", o_clear_done, o_we, o_busy, o_ready);
    end
    tick();
    i_valid = 1'b0;
    n_checks++;
    if (o_we !== ref_we(3) || o_addr !== ref_addr(7, 3) || o_data !== 12'hABC || o_clear_done !== 1'b0) begin
      n_fail++;
      $display("FAIL held_pixel we=%h addr=%0d data=%h cd=%b required %h/%0d/abc/0",
               o_we, o_addr, o_data, o_clear_done, ref_we(3), ref_addr(7, 3));
    end
  endtask

  task automatic test_reset_mid_clear();
    int bad = 0;
    i_clear = 1'b1; i_fill_color = 12'($urandom);
    tick();
    i_clear = 1'b0;
    repeat (2001) tick();
    n_checks++;
    if (o_we !== 16'hFFFF || o_addr !== 13'd2000) begin
      n_fail++;
      $display("FAIL mid_clear_reach we=%h addr=%0d required ffff/2000", o_we, o_addr);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_we !== 16'h0 || o_busy !== 1'b0 || o_addr !== 13'd0 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear_reset we=%h busy=%b addr=%0d rdy=%b required 0000/0/0/0", o_we, o_busy, o_addr, o_ready);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL mid_clear_release_ready got %b required 1", o_ready); end
    repeat (4) begin
      tick();
      if (o_we !== 16'h0 || o_busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL no_resume bad_cycles=%0d required 0", bad); end
  endtask

  task automatic test_drop_saturate();
    i_valid = 1'b1; i_x = 9'(320 + $urandom_range(0, 150)); i_y = 8'd0;
    repeat (65535) tick();
    n_checks++;
    if (o_drop_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL drop_reach got %h required ffff", o_drop_cnt); end
    tick();
    i_valid = 1'b0;
    n_checks++;
    if (o_drop_cnt !== 16'hFFFF || o_we !== 16'h0) begin
      n_fail++;
      $display("FAIL drop_saturate drop=%h we=%h required ffff/0000", o_drop_cnt, o_we);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_last_pixel();
    test_range();
    test_random();
    test_clear_pending();
    test_reset_mid_clear();
    test_drop_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
